// File: rtl/enc_pkt_pkg.sv
// Shared definitions for the encoder packet format (enc_packet / enc_depacket):
// sync byte, beat count, header field positions and the depacketiser state type.
package enc_pkt_pkg;

   localparam logic [7:0] ENC_PKT_SYNC  = 8'hA5;
   localparam int         ENC_PKT_BEATS = 3;

   localparam int HDR_SYNC_MSB = 31;
   localparam int HDR_SYNC_LSB = 24;
   localparam int HDR_USER_BIT = 0;

   typedef enum logic [1:0] {
      HDR   = 2'd0,
      HI    = 2'd1,
      LO    = 2'd2,
      FLUSH = 2'd3
   } enc_depkt_state_t;

   function automatic logic hdr_sync_ok(input logic [31:0] beat);
      return beat[HDR_SYNC_MSB:HDR_SYNC_LSB] == ENC_PKT_SYNC;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry 64+1-bit AXI-Stream output register; a load always wins over
// the handshake, so a word can be replaced in the same cycle it is consumed.
module axis_out_reg (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        load,
   input  logic [63:0] load_data,
   input  logic        load_user,
   output logic [63:0] out_data,
   output logic        out_user,
   output logic        out_valid,
   input  logic        out_ready
);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_user  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_user  <= load_user;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/enc_depacket.sv
// Reassembles three-beat 32-bit packets (header, HI, LO) into 64-bit words with
// a user flag; malformed packets are flushed up to tlast and counted.
module enc_depacket
   import enc_pkt_pkg::*;
(
   input  logic        clk,
   input  logic        aresetn,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [15:0] err_count
);

   enc_depkt_state_t state;
   logic [31:0]      data_hi;
   logic             user_hdr;
   logic             beat_acc;
   logic             load_word;
   logic             err_pulse;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Only the LO beat needs room in the output register; other beats keep flowing.
   assign s_axis_tready = !(state == LO && m_axis_tvalid && !m_axis_tready);
   assign beat_acc      = s_axis_tvalid && s_axis_tready;
   assign load_word     = beat_acc && (state == LO) && s_axis_tlast;
   assign m_axis_tlast  = m_axis_tvalid;

   assign err_pulse = beat_acc && (
        (state == HDR && (s_axis_tlast || !hdr_sync_ok(s_axis_tdata)))
     || (state == HI  && s_axis_tlast)
     || (state == LO  && !s_axis_tlast));

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= HDR;
      end else if (beat_acc) begin
         case (state)
            HDR: begin
               if (!s_axis_tlast)
                  state <= hdr_sync_ok(s_axis_tdata) ? HI : FLUSH;
            end
            HI:      state <= s_axis_tlast ? HDR : LO;
            LO:      state <= s_axis_tlast ? HDR : FLUSH;
            FLUSH:   state <= s_axis_tlast ? HDR : FLUSH;
            default: state <= HDR;
         endcase
      end
   end

   // Datapath latches carry no reset; the FSM state qualifies their use.
   always_ff @(posedge clk) begin
      if (beat_acc && state == HDR && !s_axis_tlast)
         user_hdr <= s_axis_tdata[HDR_USER_BIT];
      if (beat_acc && state == HI && !s_axis_tlast)
         data_hi <= s_axis_tdata;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         err_count <= 16'h0000;
      else if (err_pulse)
         err_count <= sat_inc(err_count);
   end

   axis_out_reg u_out (
      .clk       (clk),
      .aresetn   (aresetn),
      .load      (load_word),
      .load_data ({data_hi, s_axis_tdata}),
      .load_user (user_hdr),
      .out_data  (m_axis_tdata),
      .out_user  (m_axis_tuser),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

endmodule

// File: doc/enc_depacket.md
# enc_depacket

Stream depacketiser for the encoder data path: accepts the 32-bit, three-beat packets produced by `enc_packet` and reassembles each one into a single 64-bit word with its 1-bit user flag. It sits on the receive side of the 32-bit AXI-Stream link, for example after a DMA or loopback FIFO, and feeds 64-bit encoder consumers. Malformed packets are dropped and counted.

## Interface
- No parameters; widths fixed (in 32, out 64, user 1).
- `clk` in 1: system clock, all logic rising-edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 32: packet beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: beat accepted when high with tvalid.
- `s_axis_tlast` in 1: last beat of packet.
- `m_axis_tdata` out 64: reassembled word.
- `m_axis_tuser` out 1: user flag from header.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: high with every valid output word (one word per packet).
- `err_count` out 16: saturating count of dropped packets.

## Operation
- Packet format, beats in order:
  - Header: [31:24] = SYNC 8'hA5; [23:1] reserved, ignored on receive; [0] = tuser; tlast = 0.
  - HI: data[63:32]; tlast = 0.
  - LO: data[31:0]; tlast = 1.
- FSM states HDR, HI, LO, FLUSH; reset state HDR.
- HDR on accepted beat:
  - SYNC ok and tlast = 0: latch tuser, go to HI.
  - SYNC bad and tlast = 0: error, go to FLUSH.
  - tlast = 1 (any SYNC): error, stay in HDR.
- HI on accepted beat:
  - tlast = 0: latch data[63:32], go to LO.
  - tlast = 1: error, go to HDR.
- LO on accepted beat:
  - tlast = 1: load output register {hi, beat}, tuser; set m_axis_tvalid; go to HDR.
  - tlast = 0: error, discard the word, go to FLUSH.
- FLUSH: accept and discard beats; on tlast go to HDR.
- Error: `err_count` += 1, saturating at 16'hFFFF. At most one increment per cycle.
- Output register: single entry, AXI-Stream rules.
  - tdata/tuser stable while tvalid && !tready.
  - tvalid clears on handshake unless reloaded in the same cycle.
- `s_axis_tready` = !(state == LO && m_axis_tvalid && !m_axis_tready). Ready is high in HDR, HI and FLUSH, so the next header can overlap a stalled output.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tuser 0, m_axis_tlast 0, err_count 0, s_axis_tready 1. State = HDR.
- Latency: m_axis_tvalid rises the cycle after the LO beat handshake.
- Throughput: one 64-bit word per 3 input cycles with tready held high; no bubbles.
- Simultaneous output handshake and LO acceptance in one cycle: the new word replaces the old, tvalid stays 1, no loss.
- s_axis_tready depends combinationally on m_axis_tready in LO only; there is no combinational path from s_axis_tvalid.
- Reset asserted mid-packet: partial packet discarded, FSM to HDR, pending output word lost, err_count cleared.
- After reset release, the first beat is parsed as a header. A stream that resumes mid-packet fails SYNC, is flushed, and counted.

## Structure
- Package `enc_pkt_pkg`, shared with `enc_packet`:
  - `ENC_PKT_SYNC` = 8'hA5, `ENC_PKT_BEATS` = 3.
  - Header field positions.
  - State typedef `enc_depkt_state_t` {HDR, HI, LO, FLUSH}.
- One sub-module: `axis_out_reg`, a 64+1-bit single-entry output register with valid/ready. Everything else is inline FSM and counter.

## Test plan
- Reset with m_axis_tready = 0, then send header 32'hA500_0001, HI 32'h0000_0000, LO 32'h0000_0001 (tlast) -> one word 64'h1, tuser 1, tvalid held until tready; err_count 0.
- Ten back-to-back packets, data i = {32'hDEAD_0000 + i, 32'h0000_0000 + i}, m_axis_tready = 1 -> ten words in order, one output every 3 cycles, s_axis_tready never low.
- m_axis_tready low for 5 cycles while a second packet arrives -> s_axis_tready drops only in LO; both words delivered intact in order.
- Malformed inputs, each followed by a valid packet that must emerge correctly:
  - Header 32'h5A00_0000 followed by two beats, the last with tlast.
  - HI beat with tlast = 1.
  - LO beat with tlast = 0, then one more beat with tlast.
  - Expect err_count = 3.
- Drive 65 540 single-beat tlast packets -> err_count saturates at 16'hFFFF.
- Assert aresetn after the HI beat -> no output word; after release the next full packet is decoded correctly.
